ball_motion: RTL
================

// Module: ball_motion
// PURPOSE
//  Per-frame ball physics stage feeding map_sprite_3's ballx/bally inputs (unsigned 8.8 fixed point, map pixels).
//  Holds position and signed velocity; accepts a kick when the ball is at rest.
//  On each frame pulse from the video timing generator: integrates velocity, bounces off map walls, applies drag.
//  Sits between the game-input logic and the map sprite renderer, in the pixel clock domain.
// PARAMETERS
//  WIDTH          160      map width in pixels; x range [0,(WIDTH-1)<<8]
//  HEIGHT         90       map height in pixels; y range [0,(HEIGHT-1)<<8]
//  START_X        16'h4000 reset/start x (64.0)
//  START_Y        16'h0A00 reset/start y (10.0)
//  FRICTION_SHIFT 5        drag per frame: v <= v - (v >>> FRICTION_SHIFT)
//  MIN_SPEED      16'h0020 |v| below this after drag snaps to 0; must be >= 1<<FRICTION_SHIFT
// PORTS
//  pixel_clk_in   in   1   pixel clock
//  rst_n_in       in   1   asynchronous reset, active low
//  new_frame_in   in   1   1-cycle pulse, once per frame (start of vertical blank)
//  kick_in        in   1   1-cycle request to launch ball
//  kick_vx_in     in   16  signed 8.8 x velocity (px/frame), sampled with kick_in
//  kick_vy_in     in   16  signed 8.8 y velocity, sampled with kick_in
//  ballx_out      out  16  unsigned 8.8 x position -> map_sprite_3 ballx
//  bally_out      out  16  unsigned 8.8 y position -> map_sprite_3 bally
//  ready_out      out  1   high in IDLE: ball at rest, kick will be accepted
//  moving_out     out  1   high whenever state != IDLE
//  frame_done_out out  1   1-cycle pulse when a frame update completes
// BEHAVIOUR
//  Reset (async, rst_n_in=0): state=IDLE, x=START_X, y=START_Y, vx=vy=0, ready_out=1, moving_out=0, frame_done_out=0.
//  - Reset mid-update aborts the update immediately; no partial position is kept.
//  States: IDLE, MOVING, ADD, BOUNCE, DRAG.
//  IDLE:
//  - kick_in=1 latches vx/vy and goes to MOVING.
//  - A kick with vx=vy=0 is still accepted; the ball returns to IDLE after the next frame update.
//  - new_frame_in in IDLE does nothing.
//  MOVING: new_frame_in=1 -> ADD. kick_in is ignored in every state except IDLE.
//  ADD (cycle N+1 after the frame pulse at N): nx = x + vx, ny = y + vy, computed 18-bit signed.
//  BOUNCE (N+2): per axis, with MAX = (DIM-1)<<8:
//  - next < 0: pos = -next, v = -v.
//  - next > MAX: pos = 2*MAX - next, v = -v.
//  - otherwise pos = next.
//  - The reflected result is then clamped to [0,MAX].
//  - ballx_out/bally_out update at the end of this cycle.
//  DRAG (N+3):
//  - v = v - (v >>> FRICTION_SHIFT), arithmetic shift; then |v| < MIN_SPEED -> v = 0.
//  - frame_done_out pulses this cycle.
//  - Next state: IDLE if vx==0 && vy==0, else MOVING.
//  - A kick_in in the same cycle as the IDLE transition is ignored.
//  - new_frame_in arriving in ADD/BOUNCE/DRAG is dropped, not queued. Frames are far longer than 4 cycles.
//  - A hit on both walls in one frame is handled per axis independently, in the same BOUNCE cycle.
//  - Outputs are registered. ballx_out/bally_out are stable from BOUNCE until the next update.
//  - The renderer reads positions mid-frame; updates only happen during blanking.
// TESTING
//  1. Reset:
//     - hold rst_n_in=0 -> ballx=0x4000, bally=0x0A00, ready=1, moving=0.
//     - release, 10 frames with no kick -> no change.
//  2. Straight move:
//     - kick vx=0x0100, vy=0, then frame pulse at N.
//     - ballx=0x4100 at N+3; frame_done pulses at N+3.
//     - internal vx=0x00F8 after DRAG; second frame gives ballx=0x41F8.
//  3. Right wall:
//     - x=0x9E00, vx=0x0200, frame -> ballx=0x9E00.
//     - vx=-0x01F0 after drag.
//  4. Left wall:
//     - x=0x0100, vx=-0x0300, frame -> ballx=0x0200, vx=+0x02E8.
//     - Same test on y with HEIGHT: y=0x0100, vy=-0x0300 -> bally=0x0200.
//  5. Stop and kick rules:
//     - vx=0x0020, vy=0, frame -> vx snaps to 0, IDLE, ready=1.
//     - Kick during MOVING is ignored: velocity is unchanged.
//  6. Async reset asserted in BOUNCE -> outputs return to START at once, with no frame_done pulse.
//     - Frame pulse during DRAG is dropped: exactly one update occurs.

Source files
------------

// File: rtl/ball_motion.sv
// Per-frame ball physics: holds an 8.8 position and signed velocity, and on each
// frame pulse integrates, reflects off the map walls and applies drag.
module ball_motion #(
    parameter int          WIDTH          = 160,
    parameter int          HEIGHT         = 90,
    parameter logic [15:0] START_X        = 16'h4000,
    parameter logic [15:0] START_Y        = 16'h0A00,
    parameter int          FRICTION_SHIFT = 5,
    parameter logic [15:0] MIN_SPEED      = 16'h0020
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        new_frame_in,
    input  logic        kick_in,
    input  logic [15:0] kick_vx_in,
    input  logic [15:0] kick_vy_in,
    output logic [15:0] ballx_out,
    output logic [15:0] bally_out,
    output logic        ready_out,
    output logic        moving_out,
    output logic        frame_done_out,
    output logic [2:0]  state_dbg_out
);

    // Kick handshake: kick_in is the valid, ready_out the ready; the kick
    // velocity is taken only in a cycle where both are high.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVING = 3'd1,
        ADD    = 3'd2,
        BOUNCE = 3'd3,
        DRAG   = 3'd4
    } state_t;

    localparam logic signed [17:0] MAX_X = 18'((WIDTH - 1) * 256);
    localparam logic signed [17:0] MAX_Y = 18'((HEIGHT - 1) * 256);

    state_t             state, state_nxt;
    logic [15:0]        x, y;
    logic signed [15:0] vx, vy;
    logic signed [17:0] nx, ny;
    logic               frame_done;
    logic [16:0]        bx, by;
    logic signed [15:0] dvx, dvy;

    // Returns {flip, position}: reflect about the crossed wall, then clamp.
    function automatic logic [16:0] reflect(input logic signed [17:0] nxt,
                                            input logic signed [17:0] lim);
        logic signed [17:0] r;
        logic               flip;
        flip = 1'b1;
        if (nxt < 18'sd0) begin
            r = -nxt;
        end else if (nxt > lim) begin
            r = (lim <<< 1) - nxt;
        end else begin
            r    = nxt;
            flip = 1'b0;
        end
        if (r < 18'sd0) begin
            r = '0;
        end else if (r > lim) begin
            r = lim;
        end
        return {flip, r[15:0]};
    endfunction

    function automatic logic signed [15:0] drag(input logic signed [15:0] v);
        logic signed [15:0] d;
        logic signed [16:0] mag;
        d   = v - (v >>> FRICTION_SHIFT);
        mag = {d[15], d};
        if (mag < 17'sd0) begin
            mag = -mag;
        end
        if (mag < $signed({1'b0, MIN_SPEED})) begin
            d = '0;
        end
        return d;
    endfunction

    always_comb begin
        bx        = reflect(nx, MAX_X);
        by        = reflect(ny, MAX_Y);
        dvx       = drag(vx);
        dvy       = drag(vy);
        state_nxt = state;
        case (state)
            IDLE:    if (kick_in) state_nxt = MOVING;
            MOVING:  if (new_frame_in) state_nxt = ADD;
            ADD:     state_nxt = BOUNCE;
            BOUNCE:  state_nxt = DRAG;
            DRAG:    state_nxt = (dvx == 16'sd0 && dvy == 16'sd0) ? IDLE : MOVING;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x          <= START_X;
            y          <= START_Y;
            vx         <= '0;
            vy         <= '0;
            nx         <= '0;
            ny         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == BOUNCE);
            case (state)
                IDLE: begin
                    if (kick_in) begin
                        vx <= kick_vx_in;
                        vy <= kick_vy_in;
                    end
                end
                ADD: begin
                    nx <= $signed({2'b00, x}) + 18'(vx);
                    ny <= $signed({2'b00, y}) + 18'(vy);
                end
                BOUNCE: begin
                    x <= bx[15:0];
                    y <= by[15:0];
                    if (bx[16]) vx <= -vx;
                    if (by[16]) vy <= -vy;
                end
                DRAG: begin
                    vx <= dvx;
                    vy <= dvy;
                end
                default: ;
            endcase
        end
    end

    assign ballx_out      = x;
    assign bally_out      = y;
    assign ready_out      = (state == IDLE);
    assign moving_out     = (state != IDLE);
    assign frame_done_out = frame_done;
    assign state_dbg_out  = state;

endmodule
